// File: rtl/fifo_pkg.sv
// fifo_pkg
// Purpose : shared sizing helpers and flag reset constants for the
//           programmable-threshold FIFO (fifo_prog) and its storage (fifo_ram).
// Contents: fifo_depth()       - entry count from the address width
//           fifo_level_width() - bits needed to count 0..DEPTH inclusive
//           *_RST constants    - values the status flags take in reset
// Optional feature macro used by the FIFO: FIFO_ERR_FLAGS_EN.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // The level has to represent DEPTH itself (all entries usable), so it
  // needs one more code than the address space.
  function automatic int fifo_level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam logic EMPTY_RST        = 1'b1;
  localparam logic FULL_RST         = 1'b0;
  localparam logic ALMOST_EMPTY_RST = 1'b1;
  localparam logic ALMOST_FULL_RST  = 1'b0;
  localparam logic ERR_FLAG_RST     = 1'b0;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Purpose : DEPTH x DATA_WIDTH storage for fifo_prog with one synchronous
//           write port and one synchronous, registered read port.
// Ports   : clk   - rising-edge clock
//           rst   - synchronous active-high reset (clears only rdata)
//           we    - write enable
//           waddr - write address
//           wdata - write data
//           re    - read enable; rdata updates only when set
//           raddr - read address
//           rdata - registered read data, holds when re is low
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array. It is deliberately not reset so it maps onto a plain
  // memory; stale words are unreachable because the pointers restart.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register. A read and write to the same address on the same edge
  // returns the old word, which is what the FIFO needs when it is full and
  // both pointers coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog
// Purpose : synchronous FIFO with full-depth occupancy, programmable
//           almost-full / almost-empty thresholds, registered read data and
//           simultaneous read/write at any level.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           wr, rd, Din        - write request, read request, write data
//           af_thresh          - almost_full when level >= af_thresh
//           ae_thresh          - almost_empty when level <= ae_thresh
//           Dout, dout_valid   - registered read data and its one-cycle strobe
//           full, empty        - level == DEPTH, level == 0
//           almost_full/_empty - threshold flags
//           level              - current occupancy, 0..DEPTH
//           clr_err, overflow, underflow - sticky error flags, present only
//                                when FIFO_ERR_FLAGS_EN is defined
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic [ADDR_BITS:0]    af_thresh,
  input  logic [ADDR_BITS:0]    ae_thresh,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    level
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_BITS);
  localparam int LW    = fifo_level_width(DEPTH);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

  logic                 wr_acc;
  logic                 rd_acc;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, empty_q, almost_full_q, almost_empty_q;
  logic                 dout_valid_q;

  // Acceptance and next state. A write at full is still taken when a read
  // frees the slot on the same edge; a read at empty is always refused, so
  // wr & rd at empty just writes. The level therefore stays in 0..DEPTH.
  always_comb begin
    rd_acc   = rd & ~empty_q;
    wr_acc   = wr & (~full_q | rd);
    wr_ptr_d = wr_ptr_q + ADDR_BITS'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(rd_acc);
    level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
  end

  // Pointers, level and all status flags. Flags come from the next level,
  // never from comparing pointers, so they change on the same edge as the
  // level. Thresholds above DEPTH simply make the compare constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      full_q         <= FULL_RST;
      empty_q        <= EMPTY_RST;
      almost_full_q  <= ALMOST_FULL_RST;
      almost_empty_q <= ALMOST_EMPTY_RST;
      dout_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      full_q         <= (level_d == DEPTH_LVL);
      empty_q        <= (level_d == '0);
      almost_full_q  <= (level_d >= af_thresh);
      almost_empty_q <= (level_d <= ae_thresh);
      dout_valid_q   <= rd_acc;
    end
  end

  fifo_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(Din),
    .re   (rd_acc),
    .raddr(rd_ptr_q),
    .rdata(Dout)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags. A new rejection on the same edge as clr_err wins,
  // so an error is never lost by a badly timed clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= ERR_FLAG_RST;
      underflow_q <= ERR_FLAG_RST;
    end else begin
      overflow_q  <= (wr & ~wr_acc) | (overflow_q & ~clr_err);
      underflow_q <= (rd & ~rd_acc) | (underflow_q & ~clr_err);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign dout_valid   = dout_valid_q;

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog
// Purpose : directed testbench for fifo_prog (ADDR_BITS=3, DATA_WIDTH=8,
//           af_thresh=6, ae_thresh=1). Error-flag checks are compiled in
//           only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_prog;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] Din;
  logic [3:0] af_thresh;
  logic [3:0] ae_thresh;
  logic [7:0] Dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] level;
`ifdef FIFO_ERR_FLAGS_EN
  logic       clr_err;
  logic       overflow;
  logic       underflow;
`endif

  int testsRun;
  int testsFailed;

  fifo_prog #(
    .ADDR_BITS (3),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .rd          (rd),
    .Din         (Din),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .Dout        (Dout),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .clr_err     (clr_err),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  // Free-running clock; inputs change and outputs are sampled on the
  // falling edge, well away from the rising edge the design uses.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, let the rising edge take them, and return
  // at the next falling edge where the registered results are stable.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    Din = d;
    @(posedge clk);
    @(negedge clk);
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] drainExp [9];
    drainExp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55, 8'h00};
    testsRun    = 0;
    testsFailed = 0;
    wr  = 1'b0;
    rd  = 1'b0;
    Din = 8'h00;
    af_thresh = 4'd6;
    ae_thresh = 4'd1;
    rst = 1'b1;
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif

    // Reset, then one idle cycle.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("rst_dout", 32'(Dout), 32'h00);
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
`endif

    // Fill with 0x01..0x08; after write k the level is k.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 8'(k));
      checkOutput($sformatf("fill%0d_level", k), 32'(level), 32'(k));
      checkOutput($sformatf("fill%0d_empty", k), 32'(empty), 32'd0);
      checkOutput($sformatf("fill%0d_almost_empty", k), 32'(almost_empty), (k <= 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d_almost_full", k), 32'(almost_full), (k >= 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d_full", k), 32'(full), (k == 8) ? 32'd1 : 32'd0);
    end

    // Ninth write is rejected.
    applyStimulus(1'b1, 1'b0, 8'hAA);
    checkOutput("ovf_level", 32'(level), 32'd8);
    checkOutput("ovf_full", 32'(full), 32'd1);
    checkOutput("ovf_dout_valid", 32'(dout_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput("ovf_overflow", 32'(overflow), 32'd1);
    checkOutput("ovf_underflow", 32'(underflow), 32'd0);
`endif

    // Simultaneous read and write at full.
    applyStimulus(1'b1, 1'b1, 8'h55);
    checkOutput("fullrw_dout", 32'(Dout), 32'h01);
    checkOutput("fullrw_dout_valid", 32'(dout_valid), 32'd1);
    checkOutput("fullrw_level", 32'(level), 32'd8);
    checkOutput("fullrw_full", 32'(full), 32'd1);

    // Idle: strobe drops, data holds.
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("idle_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("idle_dout_hold", 32'(Dout), 32'h01);

    // Drain eight words across the pointer wrap.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("drain%0d_dout", k), 32'(Dout), 32'(drainExp[k]));
      checkOutput($sformatf("drain%0d_dout_valid", k), 32'(dout_valid), 32'd1);
      checkOutput($sformatf("drain%0d_level", k), 32'(level), 32'(7 - k));
    end
    checkOutput("drained_empty", 32'(empty), 32'd1);
    checkOutput("drained_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("drained_full", 32'(full), 32'd0);
    checkOutput("drained_almost_full", 32'(almost_full), 32'd0);

    // Read at empty is rejected; Dout holds.
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("udf_dout_hold", 32'(Dout), 32'h55);
    checkOutput("udf_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("udf_level", 32'(level), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput("udf_underflow", 32'(underflow), 32'd1);

    // Clear both sticky flags.
    clr_err = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("clr_underflow", 32'(underflow), 32'd0);

    // Clear coinciding with a new underflow: the set wins.
    clr_err = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    clr_err = 1'b0;
    checkOutput("clrset_underflow", 32'(underflow), 32'd1);

    clr_err = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    checkOutput("clr2_underflow", 32'(underflow), 32'd0);
`endif

    // Write and read together at empty: write wins, read refused.
    applyStimulus(1'b1, 1'b1, 8'h33);
    checkOutput("emptyrw_level", 32'(level), 32'd1);
    checkOutput("emptyrw_empty", 32'(empty), 32'd0);
    checkOutput("emptyrw_dout_valid", 32'(dout_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput("emptyrw_underflow", 32'(underflow), 32'd1);
`endif

    // Bring the level to 5, then reset mid-operation.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h10 + k));
    end
    checkOutput("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checkOutput("midrst_level", 32'(level), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("midrst_dout", 32'(Dout), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput("midrst_underflow", 32'(underflow), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow), 32'd0);
`endif

    // Fresh write then read returns the new word, not stale contents.
    applyStimulus(1'b1, 1'b0, 8'h77);
    checkOutput("post_wr_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("post_rd_dout", 32'(Dout), 32'h77);
    checkOutput("post_rd_dout_valid", 32'(dout_valid), 32'd1);
    checkOutput("post_rd_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
